scr1_pipe_mprf_wb_ctrl: RTL
===========================

// Module: scr1_pipe_mprf_wb_ctrl
// PURPOSE
//  EXU-side initiator of the MPRF write port: merges ALU results and out-of-order-in-time LSU load returns
//  into the single exu2mprf write port. Keeps a pending-load scoreboard and stalls issue on RAW/WAW hazards
//  against outstanding loads. Sits between EXU issue, ALU result path, LSU return path and the MPRF.
// PARAMETERS
//  LD_DEPTH  2   max outstanding loads (in-order rd tag FIFO depth, >=1)
//  XLEN      32  data width (= `SCR1_XLEN)
//  AWIDTH    5   register address width (= `SCR1_MPRF_AWIDTH)
// PORTS
//  clk                clk  in   1       core clock
//  rst_n              rst  in   1       reset, asynchronous, active-low
//  exu_issue_vd_i          in   1       EXU wants to issue an instruction this cycle
//  exu_issue_rdy_o         out  1       issue accepted (no hazard, tag space available)
//  exu_rs1_addr_i          in   AWIDTH  source 1 of issuing instr
//  exu_rs2_addr_i          in   AWIDTH  source 2 of issuing instr
//  exu_rd_addr_i           in   AWIDTH  destination of issuing instr
//  exu_rd_we_i             in   1       issuing instr writes rd
//  exu_is_load_i           in   1       issuing instr is a load (result returns via LSU)
//  alu_wb_vd_i             in   1       ALU result write this cycle (never stalled)
//  alu_wb_addr_i           in   AWIDTH  ALU destination
//  alu_wb_data_i           in   XLEN    ALU result
//  lsu_ret_vd_i            in   1       load data return valid
//  lsu_ret_rdy_o           out  1       load return accepted
//  lsu_ret_data_i          in   XLEN    load data (returns in issue order)
//  exu2mprf_w_req_o        out  1       MPRF write request
//  exu2mprf_rd_addr_o      out  AWIDTH  MPRF write address
//  exu2mprf_rd_data_o      out  XLEN    MPRF write data
//  wb_err_o                out  1       sticky: load return with no outstanding load
// BEHAVIOUR
//  State: pend[31:1] scoreboard (bit 0 const 0); tag FIFO (rd addrs, LD_DEPTH, wr/rd ptr + count);
//   skid reg {skid_vd, skid_addr, skid_data}; wb_err. Reset: all zero, FIFO empty.
//  Issue: exu_issue_rdy_o = ~hz & ~(exu_is_load_i & fifo_full); hz = pend[rs1] | pend[rs2] | (exu_rd_we_i & pend[rd]).
//   Combinational from registered state; cleared pend visible the cycle after the load write (no bypass).
//  Load issue (vd & rdy & is_load & rd_we & rd!=0): push rd to FIFO, set pend[rd] next edge.
//   Load with rd==0: push tag 0 (return consumed, no write, no pend bit).
//  LSU return: lsu_ret_rdy_o = ~skid_vd. Accept = vd & rdy. Accept pops FIFO head -> tag.
//   Accept with FIFO empty: no pop, no write, wb_err_o sets next edge, holds until reset.
//  Write-port arbitration, fixed priority, combinational, zero latency:
//   1) alu_wb_vd_i (alu_wb_addr_i!=0)        -> write ALU; accepted load (tag!=0) goes to skid.
//   2) skid_vd                               -> write skid; clear skid_vd, clear pend[skid_addr].
//   3) accepted load, tag!=0                 -> write directly; clear pend[tag].
//   else w_req_o=0, addr/data = 0.
//  pend clear occurs at the edge ending the MPRF write cycle; ALU write to rd==0 is dropped (w_req_o=0).
//  Skid holds at most one entry; lsu_ret_rdy_o=0 while full so no overflow; if ALU writes again while
//   skid full, skid waits (ALU never stalls).
//  Simultaneous set/clear of same pend bit impossible (WAW stall); FIFO push+pop same cycle: count unchanged.
//  ALU write to a pending register is a protocol violation (SVA under SCR1_TRGT_SIMULATION).
//  Reset mid-operation: all state cleared immediately; outstanding loads forgotten, late returns flag wb_err_o.
//  Outputs with idle inputs after reset: issue_rdy=1, lsu_ret_rdy=1, w_req=0, addr/data=0, wb_err=0.
// STRUCTURE
//  Shared package (scr1_arch_types): type_scr1_mprf_addr_e, typedef struct {vd, addr, data} type_scr1_wb_req_s.
//  One sub-module: scr1_pipe_ld_tag_fifo (LD_DEPTH x AWIDTH, push/pop/full/empty, async reset).
//  Arbiter, scoreboard and skid stay in this module.
// TESTING
//  1) Issue load rd=5; next cycle issue add rs1=5 -> rdy=0 until cycle after lsu_ret writes x5=0xDEADBEEF.
//  2) ALU wb x3=0x11 same cycle as load return for x7=0x22 -> w x3 now, w x7 next cycle, lsu_ret_rdy=0 that cycle.
//  3) Two loads (rd=8,rd=9) outstanding, third load issue -> rdy=0; returns 0xA,0xB write x8=0xA then x9=0xB.
//  4) Load rd=0 issued, returned -> no MPRF write, FIFO empty, no stall afterwards.
//  5) lsu_ret_vd with FIFO empty -> no write, wb_err_o=1 next cycle, stays 1; rst_n low clears it.
//  6) Assert rst_n low with skid full and 2 loads pending -> all pend/skid/FIFO clear, issue_rdy=1 after release.

Source files
------------

// File: rtl/scr1_pipe_mprf_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scr1_pipe_mprf_wb_ctrl_pkg
//   Architectural widths and shared types for the EXU -> MPRF write-back path.
//   - SCR1_XLEN / SCR1_MPRF_AWIDTH : default data and register-address widths
//   - type_scr1_mprf_addr_e        : named MPRF addresses with special meaning
//   - type_scr1_wb_req_s           : one MPRF write request {vd, addr, data}
// ---------------------------------------------------------------------------
package scr1_pipe_mprf_wb_ctrl_pkg;

  localparam int SCR1_XLEN        = 32;
  localparam int SCR1_MPRF_AWIDTH = 5;

  // x0 is hardwired to zero: writes to it are dropped and it is never pending.
  typedef enum logic [SCR1_MPRF_AWIDTH-1:0] {
    SCR1_MPRF_ZERO_ADDR = 5'd0,
    SCR1_MPRF_RA_ADDR   = 5'd1,
    SCR1_MPRF_SP_ADDR   = 5'd2
  } type_scr1_mprf_addr_e;

  typedef struct packed {
    logic                        vd;
    logic [SCR1_MPRF_AWIDTH-1:0] addr;
    logic [SCR1_XLEN-1:0]        data;
  } type_scr1_wb_req_s;

endpackage : scr1_pipe_mprf_wb_ctrl_pkg

// File: rtl/scr1_pipe_ld_tag_fifo.sv
// ---------------------------------------------------------------------------
// scr1_pipe_ld_tag_fifo
//   In-order FIFO of destination-register tags for outstanding loads.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset (FIFO empties)
//     push, push_data  : enqueue a tag (ignored while full)
//     pop              : dequeue the head tag (ignored while empty)
//     head             : current head tag (valid when ~empty)
//     full, empty      : occupancy flags
//   Push and pop in the same cycle leave the count unchanged.
// ---------------------------------------------------------------------------
module scr1_pipe_ld_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : scr1_pipe_ld_tag_fifo

// File: rtl/scr1_pipe_mprf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// scr1_pipe_mprf_wb_ctrl
//   EXU-side owner of the single MPRF write port. Merges ALU results and
//   in-order LSU load returns, tracks outstanding loads in a per-register
//   pending scoreboard and stalls issue on RAW/WAW hazards against them.
//   Ports:
//     clk, rst_n                     : clock, asynchronous active-low reset
//     exu_issue_vd_i/exu_issue_rdy_o : issue handshake
//     exu_rs1/rs2/rd_addr_i, exu_rd_we_i, exu_is_load_i : issuing instruction
//     alu_wb_vd_i/addr_i/data_i      : ALU result (never stalled)
//     lsu_ret_vd_i/rdy_o/data_i      : load data return handshake
//     exu2mprf_w_req_o/rd_addr_o/rd_data_o : MPRF write port
//     wb_err_o                       : sticky, load return with nothing outstanding
// ---------------------------------------------------------------------------
module scr1_pipe_mprf_wb_ctrl
  import scr1_pipe_mprf_wb_ctrl_pkg::*;
#(
  parameter int LD_DEPTH = 2,
  parameter int XLEN     = SCR1_XLEN,
  parameter int AWIDTH   = SCR1_MPRF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_issue_vd_i,
  output logic              exu_issue_rdy_o,
  input  logic [AWIDTH-1:0] exu_rs1_addr_i,
  input  logic [AWIDTH-1:0] exu_rs2_addr_i,
  input  logic [AWIDTH-1:0] exu_rd_addr_i,
  input  logic              exu_rd_we_i,
  input  logic              exu_is_load_i,
  input  logic              alu_wb_vd_i,
  input  logic [AWIDTH-1:0] alu_wb_addr_i,
  input  logic [XLEN-1:0]   alu_wb_data_i,
  input  logic              lsu_ret_vd_i,
  output logic              lsu_ret_rdy_o,
  input  logic [XLEN-1:0]   lsu_ret_data_i,
  output logic              exu2mprf_w_req_o,
  output logic [AWIDTH-1:0] exu2mprf_rd_addr_o,
  output logic [XLEN-1:0]   exu2mprf_rd_data_o,
  output logic              wb_err_o
);

  localparam int NREG = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] ZERO_ADDR = AWIDTH'(SCR1_MPRF_ZERO_ADDR);

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_set;
  logic [NREG-1:0]   pend_clr;
  logic [NREG-1:0]   pend_next;

  type_scr1_wb_req_s skid;
  type_scr1_wb_req_s wr_req;
  logic              skid_load;
  logic              skid_drain;

  logic              hz;
  logic              load_issue;
  logic [AWIDTH-1:0] ld_tag_in;

  logic              fifo_full;
  logic              fifo_empty;
  logic [AWIDTH-1:0] fifo_head;
  logic              ret_acc;
  logic              ret_pop;
  logic              ld_vd;
  logic              alu_vd;

  logic              wb_err;

  // Hazard check uses registered pend only: a register cleared by a load
  // write this cycle still stalls until the following cycle.
  assign hz = pend[exu_rs1_addr_i] | pend[exu_rs2_addr_i] |
              (exu_rd_we_i & pend[exu_rd_addr_i]);

  assign exu_issue_rdy_o = ~hz & ~(exu_is_load_i & fifo_full);
  assign load_issue      = exu_issue_vd_i & exu_issue_rdy_o & exu_is_load_i;

  // Loads without a real destination still occupy a slot so returns stay
  // aligned with the tag order; tag 0 means "consume, do not write".
  assign ld_tag_in = (exu_rd_we_i && (exu_rd_addr_i != ZERO_ADDR)) ? exu_rd_addr_i : ZERO_ADDR;

  // A full skid is the only reason to refuse a return; it drains next cycle
  // unless the ALU keeps the port busy.
  assign lsu_ret_rdy_o = ~skid.vd;
  assign ret_acc       = lsu_ret_vd_i & lsu_ret_rdy_o;
  assign ret_pop       = ret_acc & ~fifo_empty;
  assign ld_vd         = ret_pop & (fifo_head != ZERO_ADDR);
  assign alu_vd        = alu_wb_vd_i & (alu_wb_addr_i != ZERO_ADDR);

  scr1_pipe_ld_tag_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (AWIDTH)
  ) i_ld_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load_issue),
    .push_data (ld_tag_in),
    .pop       (ret_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fixed-priority write port: ALU, then skid, then a direct load return.
  // A load that loses to the ALU is parked in the skid; pend is only
  // cleared when the load data actually reaches the MPRF.
  always_comb begin
    wr_req     = '0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    pend_clr   = '0;
    if (alu_vd) begin
      wr_req.vd   = 1'b1;
      wr_req.addr = alu_wb_addr_i;
      wr_req.data = alu_wb_data_i;
      skid_load   = ld_vd;
    end else if (skid.vd) begin
      wr_req             = skid;
      skid_drain         = 1'b1;
      pend_clr[skid.addr] = 1'b1;
    end else if (ld_vd) begin
      wr_req.vd           = 1'b1;
      wr_req.addr         = fifo_head;
      wr_req.data         = lsu_ret_data_i;
      pend_clr[fifo_head] = 1'b1;
    end
  end

  always_comb begin
    pend_set = '0;
    if (load_issue && (ld_tag_in != ZERO_ADDR)) begin
      pend_set[ld_tag_in] = 1'b1;
    end
  end

  // WAW stall guarantees a bit is never set and cleared in the same cycle.
  assign pend_next = (pend | pend_set) & ~pend_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= {pend_next[NREG-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid <= '0;
    end else if (skid_load) begin
      skid.vd   <= 1'b1;
      skid.addr <= fifo_head;
      skid.data <= lsu_ret_data_i;
    end else if (skid_drain) begin
      skid.vd <= 1'b0;
    end
  end

  // A return with nothing outstanding means the LSU and EXU disagree about
  // load order; flag it until reset rather than write garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err <= 1'b0;
    end else if (ret_acc && fifo_empty) begin
      wb_err <= 1'b1;
    end
  end

  assign exu2mprf_w_req_o   = wr_req.vd;
  assign exu2mprf_rd_addr_o = wr_req.addr;
  assign exu2mprf_rd_data_o = wr_req.data;
  assign wb_err_o           = wb_err;

`ifdef SCR1_TRGT_SIMULATION
  // An ALU result targeting a register with a load in flight would be
  // silently overwritten by the later load data.
  alu_write_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(alu_wb_vd_i && pend[alu_wb_addr_i])
  ) else $error("ALU write to register with outstanding load");
`endif

endmodule : scr1_pipe_mprf_wb_ctrl
